// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between cpu and ext ports; round-robin, or fixed cpu priority with CPU_PRIORITY_EN.
// Latency: request seen in IDLE -> MEM_LAT ACCESS cycles -> Ack in cycle MEM_LAT+1; one transaction per MEM_LAT+2 cycles.
// Backpressure: requesters hold Req until Ack; the losing requester waits, its inputs sampled only when it is granted.
module mem_port_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic              cpuGnt,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRdata,
  input  logic              extReq,
  input  logic              extWe,
  input  logic [ADDR_W-1:0] extAddr,
  input  logic [DATA_W-1:0] extWdata,
  output logic              extGnt,
  output logic              extAck,
  output logic [DATA_W-1:0] extRdata,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic              memReadEn,
  output logic              memWriteEn,
  input  logic [DATA_W-1:0] memRdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  req_t             lat_q, win_req;
  logic             own_ext_q;
  logic             any_req, pick_ext, last_cycle;
  logic             owner_d, we_d, busy_d;
  logic             cpu_gnt_d, cpu_ack_d, ext_gnt_d, ext_ack_d, rd_en_d, wr_en_d;

  assign any_req    = cpuReq | extReq;
  assign last_cycle = (state_q == ACCESS) && (cnt_q == '0);

`ifdef CPU_PRIORITY_EN
  assign pick_ext = extReq & ~cpuReq;
`else
  // last_ext_q resets to 1 so the cpu wins the first tie.
  logic last_ext_q;

  assign pick_ext = extReq & (~cpuReq | ~last_ext_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ext_q <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_ext_q <= pick_ext;
    end
  end
`endif

  always_comb begin
    win_req = pick_ext ? {extWe, extAddr, extWdata} : {cpuWe, cpuAddr, cpuWdata};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered with no added latency.
  always_comb begin
    owner_d   = (state_q == IDLE) ? pick_ext : own_ext_q;
    we_d      = (state_q == IDLE) ? win_req.we : lat_q.we;
    busy_d    = (state_d != IDLE);
    cpu_gnt_d = busy_d & ~owner_d;
    ext_gnt_d = busy_d & owner_d;
    cpu_ack_d = (state_d == DONE) & ~owner_d;
    ext_ack_d = (state_d == DONE) & owner_d;
    rd_en_d   = (state_d == ACCESS) & ~we_d;
    wr_en_d   = (state_d == ACCESS) & we_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      own_ext_q  <= 1'b0;
      cpuGnt     <= 1'b0;
      cpuAck     <= 1'b0;
      extGnt     <= 1'b0;
      extAck     <= 1'b0;
      memReadEn  <= 1'b0;
      memWriteEn <= 1'b0;
      busy       <= 1'b0;
      cpuRdata   <= '0;
      extRdata   <= '0;
    end else begin
      state_q    <= state_d;
      cpuGnt     <= cpu_gnt_d;
      cpuAck     <= cpu_ack_d;
      extGnt     <= ext_gnt_d;
      extAck     <= ext_ack_d;
      memReadEn  <= rd_en_d;
      memWriteEn <= wr_en_d;
      busy       <= busy_d;
      if (state_q == IDLE && any_req) begin
        lat_q     <= win_req;
        own_ext_q <= pick_ext;
        cnt_q     <= CNT_LOAD;
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Only reads update the owner's read-data register; writes leave it holding.
      if (last_cycle && !lat_q.we) begin
        if (own_ext_q) extRdata <= memRdata;
        else           cpuRdata <= memRdata;
      end
    end
  end

  assign memAddr  = lat_q.addr;
  assign memWdata = lat_q.wdata;

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst) !(cpuGnt && extGnt));
  a_one_ack: assert property (@(posedge clk) disable iff (!rst) !(cpuAck && extAck));
  a_one_en:  assert property (@(posedge clk) disable iff (!rst) !(memReadEn && memWriteEn));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the CPU controller's fetch/operand port (cpu) and an external loader/debug port (ext).
- Grants one requester per transaction and sequences a fixed-latency, multi-cycle memory access.
- Returns a one-cycle acknowledge with read data to the granted requester.
- Sits between the CPU memory-control signals and the memory array.

Parameters:
ADDR_W, 13, memory address width
DATA_W, 8, memory data width
MEM_LAT, 2, memory access cycles per transaction (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
cpuReq  input  1  cpu transaction request, level, held until cpuAck
cpuWe  input  1  cpu write (1) / read (0)
cpuAddr  input  ADDR_W  cpu address
cpuWdata  input  DATA_W  cpu write data
cpuGnt  output  1  cpu owns memory (ACCESS and DONE)
cpuAck  output  1  one-cycle completion pulse to cpu
cpuRdata  output  DATA_W  read data, valid when cpuAck=1
extReq  input  1  ext request, same rules as cpuReq
extWe  input  1  ext write/read
extAddr  input  ADDR_W  ext address
extWdata  input  DATA_W  ext write data
extGnt  output  1  ext owns memory
extAck  output  1  one-cycle completion pulse to ext
extRdata  output  DATA_W  read data, valid when extAck=1
memAddr  output  ADDR_W  memory address
memWdata  output  DATA_W  memory write data
memReadEn  output  1  memory read enable
memWriteEn  output  1  memory write enable
memRdata  input  DATA_W  memory read data
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; lastGnt=ext, so cpu wins the first tie.
  - All outputs and latched address/data/we/rdata registers = 0.
  - Reset mid-transaction aborts immediately; no ack is issued afterwards.
- States: IDLE, ACCESS, DONE. Registered Moore outputs.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select winner, latch winner's addr/wdata/we, load counter=MEM_LAT-1, go ACCESS.
- Arbitration (round-robin):
  - Single requester wins.
  - Both requesting: grant the one not equal to lastGnt.
  - lastGnt updates on entry to ACCESS.
- ACCESS:
  - Winner's Gnt=1.
  - memAddr/memWdata driven from latched values; memReadEn=~we, memWriteEn=we. Both enables held for all MEM_LAT ACCESS cycles.
  - counter!=0: decrement. counter==0: capture memRdata into rdata register (reads only), go DONE.
- DONE:
  - Winner's Gnt=1, Ack=1 for exactly one cycle, Rdata = captured value.
  - mem enables=0; go IDLE.
- Rdata on a write transaction holds its previous value.
- Latency: request seen in IDLE at cycle 0 -> ACCESS cycles 1..MEM_LAT -> Ack in cycle MEM_LAT+1. Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- Requester rules:
  - Must drop Req in the cycle after Ack unless issuing a new transaction.
  - Req still high in the IDLE cycle after DONE counts as a new request.
  - Inputs are latched at grant, so changes after grant are ignored.
  - Req deasserted before grant is dropped with no side effects.
  - Req deasserted after grant does not cancel the transaction; Ack is still issued.
- Never: both Gnt high together; both Acks high together; memReadEn and memWriteEn high together; mem enables active outside ACCESS.
- Non-granted Ack/Gnt=0; Rdata holds its last value.

Optional Feature:
- Macro: CPU_PRIORITY_EN.
- Defined: fixed priority. cpu always wins when both request; lastGnt is ignored for arbitration.
- Undefined: round-robin as described above.
- Single-requester behaviour is identical either way.

Test Plan:
- rst=0 for 2 cycles, random inputs -> all outputs 0, busy=0; after release with no Req, outputs stay 0.
- MEM_LAT=2, cpu read cpuAddr=0x005, memRdata=0xA5 -> memReadEn=1 and memAddr=0x005 in cycles 1-2; cpuGnt in cycles 1-3; cpuAck=1 only in cycle 3 with cpuRdata=0xA5; memWriteEn never 1.
- ext write extAddr=0x1FFF, extWdata=0x3C -> memWriteEn=1, memAddr=0x1FFF, memWdata=0x3C in cycles 1-2; extAck in cycle 3; cpuGnt/cpuAck stay 0.
- cpuReq and extReq raised together in cycle 0 after reset, each dropped after its Ack -> cpu ACCESS 1-2, cpuAck 3; IDLE 4; ext ACCESS 5-6, extAck 7.
- Both Req held continuously for 4 transactions -> grants alternate cpu, ext, cpu, ext. With CPU_PRIORITY_EN defined -> cpu granted all 4, extAck never.
- cpu read in flight, rst=0 asserted in cycle 2 (ACCESS), released in cycle 4 -> outputs 0 from assertion; no cpuAck afterwards while cpuReq=0; next tie goes to cpu.
